md_sequencer: RTL and testbench
===============================

// Module: md_sequencer
// PURPOSE
//   Initiator side of the DIVMULT multiply/divide unit. It accepts one mult/div request from CPU
//   control and drives DIVMULT's A/B/MDControl/start. It waits the unit's fixed latency, then
//   pulses the load of the HI/LO registers. It also detects divide-by-zero, supports flush, and
//   exports busy/done so control can stall.
// PARAMETERS
//   W        32  operand / result width
//   MULT_LAT 32  cycles from md_start to valid DIVMULT result, multiply (>=1)
//   DIV_LAT  33  cycles from md_start to valid DIVMULT result, divide (>=1)
// PORTS
//   clk          in   1  clock, rising edge
//   reset        in   1  asynchronous, active-low reset
//   req_valid    in   1  request present
//   req_op       in   1  0 = mult, 1 = div (drives MDControl)
//   req_a        in   W  operand A
//   req_b        in   W  operand B
//   req_ready    out  1  sequencer can accept (state IDLE)
//   flush        in   1  cancel in-flight op, no HI/LO write
//   md_a         out  W  to DIVMULT A
//   md_b         out  W  to DIVMULT B
//   md_control   out  1  to DIVMULT MDControl
//   md_start     out  1  one-cycle start pulse to DIVMULT
//   hilo_load    out  1  one-cycle load enable to HI and LO registers
//   busy         out  1  op in flight (state != IDLE)
//   done         out  1  one-cycle completion pulse
//   div0_exc     out  1  one-cycle pulse, coincident with done, on div with B==0
// BEHAVIOUR
//   Reset (reset==0, async): state=IDLE, counter=0, md_a=md_b=0, md_control=0. All pulses are 0.
//     req_ready=1 after release.
//   States: IDLE, ISSUE, WAIT, WRITE, DONE. All outputs are registered or decoded from state.
//   IDLE: req_ready=1. On req_valid at edge N, latch req_a/req_b/req_op into md_a/md_b/md_control.
//     If req_op=1 and req_b==0, go to DONE with div0 flag set; otherwise go to ISSUE.
//   ISSUE (cycle N+1): md_start=1. Load counter with LAT-1 (LAT=MULT_LAT or DIV_LAT per op).
//     Go to WAIT.
//   WAIT (LAT cycles, N+2..N+1+LAT): counter decrements each cycle. When counter==0, go to WRITE.
//   WRITE (cycle N+2+LAT): hilo_load=1 for exactly one cycle. Go to DONE.
//   DONE (cycle N+3+LAT): done=1 for exactly one cycle. div0_exc=div0 flag. Clear flag.
//     Go to IDLE; the next request can be accepted at N+4+LAT.
//   Div0 path: done and div0_exc both =1 at N+1. md_start and hilo_load are never asserted,
//     so HI/LO keep their old values.
//   md_a/md_b/md_control hold their values from accept until the next accept. They are stable
//     for the whole DIVMULT operation.
//   flush:
//     - In ISSUE/WAIT/WRITE: go to IDLE next edge. No hilo_load, no done.
//     - If flush and hilo_load would coincide in WRITE, flush wins and load is suppressed.
//     - In DONE: ignored.
//     - In IDLE: highest priority; blocks acceptance that cycle.
//   req_valid outside IDLE: ignored, not queued (req_ready=0).
//   Counter width: $clog2(max(MULT_LAT,DIV_LAT)). No wrap; it is reloaded only in ISSUE.
//   Async reset mid-operation: aborts immediately. No further md_start/hilo_load/done.
// TESTING
//   Mult 7*6, MULT_LAT=32, accept at N -> md_start at N+1 only, hilo_load at N+34 only,
//     done at N+35, div0_exc=0.
//   Div 100/0 -> done=div0_exc=1 at N+1. md_start and hilo_load stay 0 throughout.
//     req_ready back to 1 at N+2.
//   Div 100/7, DIV_LAT=33 -> md_control=1 and md_b=7 held N+1..N+35. hilo_load at N+35.
//   flush at N+10 during WAIT -> state IDLE at N+11. No hilo_load/done. Next request accepted.
//   Back-to-back: req_valid held high -> second accept only at the cycle after done.
//     req_ready=0 in between.
//   reset=0 asserted mid-WAIT -> all outputs reach reset values without a clock edge.
//     No hilo_load after release.

Source files
------------

// File: rtl/md_sequencer.sv
// -----------------------------------------------------------------------------
// md_sequencer
//   Initiator side of the DIVMULT multiply/divide unit. It accepts one
//   mult/div request and presents the operands and the operation to DIVMULT.
//   It then issues a one-cycle start pulse and waits the unit's fixed latency.
//   After that it pulses the HI/LO load enable, and then a done pulse.
//   A divide by zero skips DIVMULT entirely: done and div0_exc pulse together
//   and HI/LO are left untouched. A flush cancels an operation that is still
//   in flight.
//
// Ports
//   clk, reset          clock (rising edge), asynchronous active-low reset
//   req_valid/req_op    request strobe; op 0 = mult, 1 = div
//   req_a/req_b         operands
//   req_ready           high while idle (a request can be accepted)
//   flush               cancel an in-flight op (no HI/LO write, no done)
//   md_a/md_b           operands to DIVMULT, held from accept to next accept
//   md_control          MDControl to DIVMULT, held like the operands
//   md_start            one-cycle start pulse to DIVMULT
//   hilo_load           one-cycle load enable for the HI and LO registers
//   busy                op in flight (not idle)
//   done                one-cycle completion pulse
//   div0_exc            divide-by-zero pulse, coincident with done
// -----------------------------------------------------------------------------
module md_sequencer #(
   parameter int W        = 32,
   parameter int MULT_LAT = 32,
   parameter int DIV_LAT  = 33
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req_valid,
   input  logic         req_op,
   input  logic [W-1:0] req_a,
   input  logic [W-1:0] req_b,
   output logic         req_ready,
   input  logic         flush,
   output logic [W-1:0] md_a,
   output logic [W-1:0] md_b,
   output logic         md_control,
   output logic         md_start,
   output logic         hilo_load,
   output logic         busy,
   output logic         done,
   output logic         div0_exc
);

   localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
   // A single-cycle latency still needs a one-bit counter.
   localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_LAT - 1);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_LAT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_WRITE,
      S_DONE
   } state_t;

   state_t           state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [W-1:0]     a_q;
   logic [W-1:0]     b_q;
   logic             ctrl_q;
   logic             div0_q;

   // NOTE: every register, operands included, is cleared by the async reset so
   // DIVMULT sees defined inputs; state uses non-blocking assignments only.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         ctrl_q  <= 1'b0;
         div0_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               // flush outranks a request that arrives in the same cycle
               if (!flush && req_valid) begin
                  a_q    <= req_a;
                  b_q    <= req_b;
                  ctrl_q <= req_op;
                  if (req_op && (req_b == '0)) begin
                     div0_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_ISSUE: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else begin
                  // counting LAT-1 down to 0 gives exactly LAT cycles in WAIT
                  cnt_q   <= ctrl_q ? DIV_LOAD : MULT_LOAD;
                  state_q <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (flush) begin
                  state_q <= S_IDLE;
               end else if (cnt_q == '0) begin
                  state_q <= S_WRITE;
               end else begin
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            S_WRITE: begin
               state_q <= flush ? S_IDLE : S_DONE;
            end
            S_DONE: begin
               // flush is ignored here: the result is already committed
               div0_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign md_a       = a_q;
   assign md_b       = b_q;
   assign md_control = ctrl_q;
   assign req_ready  = (state_q == S_IDLE);
   assign busy       = (state_q != S_IDLE);
   assign md_start   = (state_q == S_ISSUE);
   // A flush arriving in the WRITE cycle must still keep HI/LO unchanged, so
   // the load enable is gated by flush directly rather than by the next state.
   assign hilo_load  = (state_q == S_WRITE) && !flush;
   assign done       = (state_q == S_DONE);
   assign div0_exc   = (state_q == S_DONE) && div0_q;

endmodule

// File: tb/tb_md_sequencer.sv
// -----------------------------------------------------------------------------
// tb_md_sequencer
//   Scoreboard bench for md_sequencer. The driver keeps a cycle-number model of
//   the sequencer: when a request is accepted, it predicts the cycles of
//   md_start, hilo_load and done and queues them. A separate monitor pops and
//   compares whenever one of those pulses appears or falls due.
// -----------------------------------------------------------------------------
module tb_md_sequencer;

   localparam int W        = 32;
   localparam int MULT_LAT = 32;
   localparam int DIV_LAT  = 33;

   logic         clk = 1'b0;
   logic         reset;
   logic         req_valid;
   logic         req_op;
   logic [W-1:0] req_a;
   logic [W-1:0] req_b;
   logic         req_ready;
   logic         flush;
   logic [W-1:0] md_a;
   logic [W-1:0] md_b;
   logic         md_control;
   logic         md_start;
   logic         hilo_load;
   logic         busy;
   logic         done;
   logic         div0_exc;

   always #5 clk = ~clk;

   md_sequencer #(
      .W        (W),
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_op     (req_op),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_ready  (req_ready),
      .flush      (flush),
      .md_a       (md_a),
      .md_b       (md_b),
      .md_control (md_control),
      .md_start   (md_start),
      .hilo_load  (hilo_load),
      .busy       (busy),
      .done       (done),
      .div0_exc   (div0_exc)
   );

   // An expected pulse: the cycle it must be seen in (number of rising edges
   // so far, sampled at the falling edge) plus the data that goes with it.
   typedef struct {
      int           cyc;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         ctrl;
      logic         div0;
   } ev_t;

   ev_t start_q[$];
   ev_t load_q[$];
   ev_t done_q[$];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model state. Everything is expressed as cycle numbers:
   // next_free is the first rising edge at which a new request may be taken.
   int           next_free = 0;
   logic [W-1:0] held_a    = '0;
   logic [W-1:0] held_b    = '0;
   logic         held_ctrl = 1'b0;
   logic         act       = 1'b0;
   int           cur_e     = 0;
   int           cur_lat   = 0;
   logic         cur_div0  = 1'b0;

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, actual, expected, cyc);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  64'(req_ready),  64'(1));
      check({tag, "_busy"},       64'(busy),       64'(0));
      check({tag, "_md_a"},       64'(md_a),       64'(0));
      check({tag, "_md_b"},       64'(md_b),       64'(0));
      check({tag, "_md_control"}, 64'(md_control), 64'(0));
      check({tag, "_md_start"},   64'(md_start),   64'(0));
      check({tag, "_hilo_load"},  64'(hilo_load),  64'(0));
      check({tag, "_done"},       64'(done),       64'(0));
      check({tag, "_div0_exc"},   64'(div0_exc),   64'(0));
   endtask

   // One clock of stimulus. The values driven here are sampled at the next
   // rising edge, while the outputs visible now belong to the current cycle.
   task automatic drive(input logic v, input logic op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic fl);
      int   c;
      int   lat;
      logic idle;
      ev_t  e;
      @(posedge clk);
      #1;
      c    = cyc;
      idle = (c + 1 >= next_free);
      check("req_ready",  64'(req_ready),  64'(idle));
      check("busy",       64'(busy),       64'(!idle));
      check("md_a_hold",  64'(md_a),       64'(held_a));
      check("md_b_hold",  64'(md_b),       64'(held_b));
      check("md_ctl_hold", 64'(md_control), 64'(held_ctrl));

      // Flush cancels a normal op from its start cycle through its load cycle.
      if (fl && act && !cur_div0 && c >= cur_e && c <= cur_e + 1 + cur_lat) begin
         act       = 1'b0;
         next_free = c + 2;
         for (int i = load_q.size() - 1; i >= 0; i--)
            if (load_q[i].cyc >= c) load_q.delete(i);
         for (int i = done_q.size() - 1; i >= 0; i--)
            if (done_q[i].cyc > c) done_q.delete(i);
      end

      if (idle && v && !fl) begin
         held_a    = a;
         held_b    = b;
         held_ctrl = op;
         cur_e     = c + 1;
         act       = 1'b1;
         cur_div0  = op && (b == '0);
         lat       = op ? DIV_LAT : MULT_LAT;
         cur_lat   = lat;
         e.a       = a;
         e.b       = b;
         e.ctrl    = op;
         e.div0    = cur_div0;
         if (cur_div0) begin
            e.cyc = cur_e;
            done_q.push_back(e);
            next_free = cur_e + 2;
         end else begin
            e.cyc = cur_e;
            start_q.push_back(e);
            e.cyc = cur_e + 1 + lat;
            load_q.push_back(e);
            e.cyc = cur_e + 2 + lat;
            done_q.push_back(e);
            next_free = cur_e + lat + 4;
         end
      end

      req_valid = v;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      flush     = fl;
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) drive(1'b0, 1'b0, '0, '0, 1'b0);
   endtask

   // Monitor: compare each pulse against the head of its queue, and flag any
   // expected pulse whose cycle has passed without it appearing.
   always @(negedge clk) begin
      ev_t e;
      if (reset) begin
         if (md_start) begin
            if (start_q.size() == 0) check("md_start_unexpected", 64'(md_start), 64'(0));
            else begin
               e = start_q.pop_front();
               check("md_start_cycle", 64'(cyc), 64'(e.cyc));
               check("md_start_a",     64'(md_a), 64'(e.a));
               check("md_start_b",     64'(md_b), 64'(e.b));
               check("md_start_ctl",   64'(md_control), 64'(e.ctrl));
            end
         end else if (start_q.size() != 0 && start_q[0].cyc <= cyc) begin
            e = start_q.pop_front();
            check("md_start_missing", 64'(md_start), 64'(1));
         end

         if (hilo_load) begin
            if (load_q.size() == 0) check("hilo_load_unexpected", 64'(hilo_load), 64'(0));
            else begin
               e = load_q.pop_front();
               check("hilo_load_cycle", 64'(cyc), 64'(e.cyc));
               check("hilo_load_ctl",   64'(md_control), 64'(e.ctrl));
               check("hilo_load_b",     64'(md_b), 64'(e.b));
            end
         end else if (load_q.size() != 0 && load_q[0].cyc <= cyc) begin
            e = load_q.pop_front();
            check("hilo_load_missing", 64'(hilo_load), 64'(1));
         end

         if (done) begin
            if (done_q.size() == 0) check("done_unexpected", 64'(done), 64'(0));
            else begin
               e = done_q.pop_front();
               check("done_cycle", 64'(cyc), 64'(e.cyc));
               check("div0_exc",   64'(div0_exc), 64'(e.div0));
            end
         end else begin
            if (div0_exc) check("div0_without_done", 64'(div0_exc), 64'(0));
            if (done_q.size() != 0 && done_q[0].cyc <= cyc) begin
               e = done_q.pop_front();
               check("done_missing", 64'(done), 64'(1));
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset     = 1'b0;
      req_valid = 1'b0;
      req_op    = 1'b0;
      req_a     = '0;
      req_b     = '0;
      flush     = 1'b0;
      #1;
      check_reset_outputs("reset");
      repeat (3) @(posedge clk);
      #3;
      reset = 1'b1;
      idle_cycles(2);

      // Mult 7*6, div 100/0, div 100/7
      drive(1'b1, 1'b0, 32'd7, 32'd6, 1'b0);
      idle_cycles(MULT_LAT + 6);
      drive(1'b1, 1'b1, 32'd100, 32'd0, 1'b0);
      idle_cycles(4);
      drive(1'b1, 1'b1, 32'd100, 32'd7, 1'b0);
      idle_cycles(DIV_LAT + 6);

      // Flush during WAIT, then a fresh request right away
      drive(1'b1, 1'b0, 32'd11, 32'd12, 1'b0);
      idle_cycles(9);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      drive(1'b1, 1'b0, 32'd3, 32'd4, 1'b0);
      idle_cycles(MULT_LAT + 6);

      // Flush coinciding with the load cycle, then flush in DONE (ignored)
      drive(1'b1, 1'b0, 32'd5, 32'd9, 1'b0);
      idle_cycles(MULT_LAT + 1);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      idle_cycles(4);
      drive(1'b1, 1'b1, 32'd50, 32'd5, 1'b0);
      idle_cycles(DIV_LAT + 2);
      drive(1'b0, 1'b0, '0, '0, 1'b1);
      idle_cycles(4);

      // Flush in IDLE blocks a simultaneous request
      drive(1'b1, 1'b0, 32'd1, 32'd2, 1'b1);
      idle_cycles(2);

      // Back-to-back with req_valid held high
      repeat (90) drive(1'b1, 1'($urandom_range(0, 1)), W'($urandom), W'($urandom), 1'b0);

      // Randomized traffic
      repeat (3000) begin
         drive(1'($urandom_range(0, 2) != 0),
               1'($urandom_range(0, 1)),
               W'($urandom),
               ($urandom_range(0, 3) == 0) ? '0 : W'($urandom),
               1'($urandom_range(0, 29) == 0));
      end
      idle_cycles(DIV_LAT + 6);
      check("queues_drained", 64'(start_q.size() + load_q.size() + done_q.size()), 64'(0));

      // Async reset in the middle of WAIT
      drive(1'b1, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
      idle_cycles(10);
      #2;
      reset = 1'b0;
      start_q.delete();
      load_q.delete();
      done_q.delete();
      next_free = 0;
      held_a    = '0;
      held_b    = '0;
      held_ctrl = 1'b0;
      act       = 1'b0;
      #1;
      check_reset_outputs("midwait_reset");
      repeat (2) @(posedge clk);
      #3;
      reset = 1'b1;
      idle_cycles(MULT_LAT + 10);
      drive(1'b1, 1'b0, 32'd2, 32'd3, 1'b0);
      idle_cycles(MULT_LAT + 6);
      check("final_drain", 64'(start_q.size() + load_q.size() + done_q.size()), 64'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
